// File: rtl/zeroheti_obi_apb_bridge.sv
// OBI subordinate to APB4 manager bridge for the peripheral window.
// Accepts one OBI request at a time, decodes it onto one of NumApbSbrs
// APB subordinates, runs SETUP/ACCESS and returns a single OBI response.
// Unmapped addresses and peripherals that never raise PREADY get an error.
module zeroheti_obi_apb_bridge #(
  parameter logic [31:0] BaseAddr      = 32'h0003_0000,
  parameter int unsigned NumApbSbrs    = 4,
  parameter logic [31:0] SbrSize       = 32'h0000_1000,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     obi_req_i,
  output logic                     obi_gnt_o,
  input  logic [31:0]              obi_addr_i,
  input  logic                     obi_we_i,
  input  logic [3:0]               obi_be_i,
  input  logic [31:0]              obi_wdata_i,
  output logic                     obi_rvalid_o,
  output logic [31:0]              obi_rdata_o,
  output logic                     obi_err_o,
  output logic [NumApbSbrs-1:0]    psel_o,
  output logic                     penable_o,
  output logic                     pwrite_o,
  output logic [31:0]              paddr_o,
  output logic [31:0]              pwdata_o,
  output logic [3:0]               pstrb_o,
  output logic [2:0]               pprot_o,
  input  logic [NumApbSbrs*32-1:0] prdata_i,
  input  logic [NumApbSbrs-1:0]    pready_i,
  input  logic [NumApbSbrs-1:0]    pslverr_i
);

  localparam int unsigned SbrShift    = $clog2(SbrSize);
  localparam int unsigned IdxW        = (NumApbSbrs > 1) ? $clog2(NumApbSbrs) : 1;
  localparam logic [32:0] WinSize     = 33'(NumApbSbrs) * {1'b0, SbrSize};
  localparam logic [31:0] OffsMask    = (SbrSize - 32'd1) & ~32'h3;
  localparam logic [31:0] TimeoutLast = 32'(TimeoutCycles - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic            we_q;
  logic [3:0]      be_q;
  logic [31:0]     wdata_q;
  logic [IdxW-1:0] idx_q;
  logic [31:0]     paddr_q;
  logic            mapped_q;
  logic [31:0]     rdata_q;
  logic            err_q;
  logic [31:0]     cnt_q;

  logic [32:0]     dec_offs;
  logic [32:0]     dec_shifted;
  logic            dec_mapped;
  logic [IdxW-1:0] dec_idx;
  logic [31:0]     dec_paddr;

  logic            sel_ready;
  logic            sel_err;
  logic [31:0]     sel_rdata;
  logic            timeout_hit;
  logic            handshake;

  // Address decode, done in 33 bits so addresses near 2^32 cannot wrap into the window
  assign dec_offs    = {1'b0, obi_addr_i} - {1'b0, BaseAddr};
  assign dec_mapped  = (obi_addr_i >= BaseAddr) && (dec_offs < WinSize);
  assign dec_shifted = dec_offs >> SbrShift;
  assign dec_idx     = dec_shifted[IdxW-1:0];
  assign dec_paddr   = dec_offs[31:0] & OffsMask;

  // Only the currently selected subordinate's handshake signals matter
  assign sel_ready   = pready_i[idx_q];
  assign sel_err     = pslverr_i[idx_q];
  assign sel_rdata   = prdata_i[32'(idx_q) * 32 +: 32];
  assign timeout_hit = (TimeoutCycles != 0) && (cnt_q == TimeoutLast);
  assign handshake   = obi_gnt_o;
  assign pprot_o     = 3'b000;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and all bus outputs; grant is masked while reset is held
  always_comb begin
    state_d      = state_q;
    obi_gnt_o    = 1'b0;
    obi_rvalid_o = 1'b0;
    obi_rdata_o  = 32'h0;
    obi_err_o    = 1'b0;
    psel_o       = '0;
    penable_o    = 1'b0;
    pwrite_o     = 1'b0;
    paddr_o      = 32'h0;
    pwdata_o     = 32'h0;
    pstrb_o      = 4'b0000;
    case (state_q)
      IDLE: begin
        obi_gnt_o = obi_req_i && rst_ni;
        if (obi_gnt_o) begin
          state_d = dec_mapped ? SETUP : RESP;
        end
      end
      SETUP, ACCESS: begin
        psel_o[idx_q] = mapped_q;
        penable_o     = (state_q == ACCESS);
        pwrite_o      = we_q;
        paddr_o       = paddr_q;
        pwdata_o      = wdata_q;
        pstrb_o       = we_q ? be_q : 4'b0000;
        if (state_q == SETUP) begin
          state_d = ACCESS;
        end else if (sel_ready || timeout_hit) begin
          state_d = RESP;
        end
      end
      RESP: begin
        obi_rvalid_o = 1'b1;
        obi_rdata_o  = rdata_q;
        obi_err_o    = err_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latches on the handshake, response capture at the end of ACCESS
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q     <= 1'b0;
      be_q     <= 4'b0000;
      wdata_q  <= 32'h0;
      idx_q    <= '0;
      paddr_q  <= 32'h0;
      mapped_q <= 1'b0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else if (state_q == IDLE && handshake) begin
      we_q     <= obi_we_i;
      be_q     <= obi_be_i;
      wdata_q  <= obi_wdata_i;
      idx_q    <= dec_idx;
      paddr_q  <= dec_paddr;
      mapped_q <= dec_mapped;
      rdata_q  <= 32'h0;
      err_q    <= !dec_mapped;
    end else if (state_q == ACCESS) begin
      if (sel_ready) begin
        rdata_q <= we_q ? 32'h0 : sel_rdata;
        err_q   <= sel_err;
      end else if (timeout_hit) begin
        rdata_q <= 32'h0;
        err_q   <= 1'b1;
      end
    end
  end

  // Wait-state counter, runs only while in ACCESS
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 32'h0;
    end else if (state_q == ACCESS) begin
      cnt_q <= cnt_q + 32'd1;
    end else begin
      cnt_q <= 32'h0;
    end
  end

endmodule

// File: tb/tb_zeroheti_obi_apb_bridge.sv
// Self-checking bench for zeroheti_obi_apb_bridge: a small APB responder
// model per subordinate and a response scoreboard for the OBI side.
module tb_zeroheti_obi_apb_bridge;

  localparam logic [31:0] Base = 32'h0003_0000;
  localparam int          NSbr = 4;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              obi_req_i;
  logic              obi_gnt_o;
  logic [31:0]       obi_addr_i;
  logic              obi_we_i;
  logic [3:0]        obi_be_i;
  logic [31:0]       obi_wdata_i;
  logic              obi_rvalid_o;
  logic [31:0]       obi_rdata_o;
  logic              obi_err_o;
  logic [NSbr-1:0]   psel_o;
  logic              penable_o;
  logic              pwrite_o;
  logic [31:0]       paddr_o;
  logic [31:0]       pwdata_o;
  logic [3:0]        pstrb_o;
  logic [2:0]        pprot_o;
  logic [NSbr*32-1:0] prdata_i;
  logic [NSbr-1:0]   pready_i;
  logic [NSbr-1:0]   pslverr_i;

  int checks = 0;
  int errors = 0;
  resp_t expQ[$];

  // Responder configuration per subordinate
  int          waitCfg[NSbr];
  int          accCnt[NSbr];
  logic        hangCfg[NSbr];
  logic        errCfg[NSbr];
  logic        strayReady[NSbr];
  logic        strayErr[NSbr];
  logic [31:0] rdataCfg[NSbr];

  zeroheti_obi_apb_bridge #(
    .BaseAddr(Base),
    .NumApbSbrs(NSbr),
    .SbrSize(32'h0000_1000),
    .TimeoutCycles(255)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .obi_req_i(obi_req_i),
    .obi_gnt_o(obi_gnt_o),
    .obi_addr_i(obi_addr_i),
    .obi_we_i(obi_we_i),
    .obi_be_i(obi_be_i),
    .obi_wdata_i(obi_wdata_i),
    .obi_rvalid_o(obi_rvalid_o),
    .obi_rdata_o(obi_rdata_o),
    .obi_err_o(obi_err_o),
    .psel_o(psel_o),
    .penable_o(penable_o),
    .pwrite_o(pwrite_o),
    .paddr_o(paddr_o),
    .pwdata_o(pwdata_o),
    .pstrb_o(pstrb_o),
    .pprot_o(pprot_o),
    .prdata_i(prdata_i),
    .pready_i(pready_i),
    .pslverr_i(pslverr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // APB responder: counts ACCESS cycles of each selected subordinate and raises PREADY after its wait states
  always @(negedge clk_i) begin
    for (int s = 0; s < NSbr; s++) begin
      if (psel_o[s] && penable_o) begin
        accCnt[s]++;
        pready_i[s] = !hangCfg[s] && (accCnt[s] > waitCfg[s]);
      end else begin
        accCnt[s]   = 0;
        pready_i[s] = strayReady[s];
      end
      pslverr_i[s] = errCfg[s] ? pready_i[s] : (strayErr[s] && !pready_i[s]);
      prdata_i[s*32 +: 32] = rdataCfg[s];
    end
  end

  // Response monitor: every rvalid pops the scoreboard, idle cycles must show zero data/err
  always @(negedge clk_i) begin
    resp_t exp;
    if (rst_ni) begin
      if (obi_rvalid_o) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_rvalid", 64'(obi_rvalid_o), 64'd0);
        end else begin
          exp = expQ.pop_front();
          checkOutput("resp_rdata", 64'(obi_rdata_o), 64'(exp.rdata));
          checkOutput("resp_err", 64'(obi_err_o), 64'(exp.err));
        end
      end else begin
        checkOutput("idle_resp_zero", 64'({obi_rdata_o, obi_err_o}), 64'd0);
      end
    end
  end

  // Drive one request until granted, push its expected response, release req after the handshake edge
  task automatic applyStimulus(input logic [31:0] addr, input logic we, input logic [3:0] be,
                               input logic [31:0] wdata, input logic [31:0] expRdata, input logic expErr);
    bit granted = 0;
    @(negedge clk_i);
    obi_req_i   = 1'b1;
    obi_addr_i  = addr;
    obi_we_i    = we;
    obi_be_i    = be;
    obi_wdata_i = wdata;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (obi_gnt_o) begin
        granted = 1;
        break;
      end
      @(negedge clk_i);
    end
    if (!granted) begin
      checkOutput("gnt_timeout", 64'd0, 64'd1);
    end else begin
      expQ.push_back('{rdata: expRdata, err: expErr});
    end
    @(posedge clk_i);
    #1;
    obi_req_i = 1'b0;
  endtask

  task automatic waitResponse(input string tag, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (obi_rvalid_o) begin
        seen = 1;
        break;
      end
    end
    if (!seen) checkOutput(tag, 64'd0, 64'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int penCnt;
    int grants[3];
    int nGrant;

    for (int s = 0; s < NSbr; s++) begin
      waitCfg[s] = 0; accCnt[s] = 0; hangCfg[s] = 0; errCfg[s] = 0;
      strayReady[s] = 0; strayErr[s] = 0; rdataCfg[s] = 32'h0;
    end
    pready_i = '0; pslverr_i = '0; prdata_i = '0;
    rst_ni = 1'b0;
    obi_req_i = 1'b1;
    obi_addr_i = Base; obi_we_i = 1'b0; obi_be_i = 4'h0; obi_wdata_i = 32'h0;

    // Reset state: everything quiet, no grant even with req high
    @(negedge clk_i);
    @(negedge clk_i);
    checkOutput("rst_gnt", 64'(obi_gnt_o), 64'd0);
    checkOutput("rst_psel", 64'(psel_o), 64'd0);
    checkOutput("rst_apb", 64'({penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o, pprot_o}), 64'd0);
    checkOutput("rst_resp", 64'({obi_rvalid_o, obi_rdata_o, obi_err_o}), 64'd0);
    obi_req_i = 1'b0;
    rst_ni = 1'b1;

    // 1: zero-wait write to sub 1
    applyStimulus(Base + 32'h1008, 1'b1, 4'b0011, 32'hDEAD_BEEF, 32'h0, 1'b0);
    @(negedge clk_i);
    checkOutput("t1_setup_psel", 64'(psel_o), 64'(4'b0010));
    checkOutput("t1_setup_penable", 64'(penable_o), 64'd0);
    checkOutput("t1_setup_paddr", 64'(paddr_o), 64'h8);
    checkOutput("t1_setup_pstrb", 64'(pstrb_o), 64'(4'b0011));
    checkOutput("t1_setup_pwrite", 64'(pwrite_o), 64'd1);
    checkOutput("t1_setup_pwdata", 64'(pwdata_o), 64'hDEAD_BEEF);
    @(negedge clk_i);
    checkOutput("t1_access_penable", 64'({psel_o, penable_o}), 64'({4'b0010, 1'b1}));
    @(negedge clk_i);
    checkOutput("t1_rvalid_T3", 64'(obi_rvalid_o), 64'd1);
    checkOutput("t1_resp_psel", 64'({psel_o, penable_o}), 64'd0);

    // 2: read sub 3 with two wait states
    waitCfg[3] = 2;
    rdataCfg[3] = 32'h1234_5678;
    applyStimulus(Base + 32'h3004, 1'b0, 4'b1111, 32'h0, 32'h1234_5678, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk_i);
      checkOutput("t2_psel_stable", 64'(psel_o), 64'(4'b1000));
      checkOutput("t2_pstrb_read", 64'(pstrb_o), 64'd0);
      checkOutput("t2_paddr", 64'(paddr_o), 64'h4);
      checkOutput("t2_penable", 64'(penable_o), 64'(c != 1));
      checkOutput("t2_no_early_rvalid", 64'(obi_rvalid_o), 64'd0);
    end
    @(negedge clk_i);
    checkOutput("t2_rvalid_T5", 64'(obi_rvalid_o), 64'd1);

    // 3: unmapped above the window and below the base
    applyStimulus(Base + 32'h4000, 1'b0, 4'b1111, 32'h0, 32'h0, 1'b1);
    @(negedge clk_i);
    checkOutput("t3_hi_rvalid_T1", 64'(obi_rvalid_o), 64'd1);
    checkOutput("t3_hi_psel", 64'(psel_o), 64'd0);
    applyStimulus(Base - 32'd4, 1'b0, 4'b1111, 32'h0, 32'h0, 1'b1);
    @(negedge clk_i);
    checkOutput("t3_lo_rvalid_T1", 64'(obi_rvalid_o), 64'd1);
    checkOutput("t3_lo_psel", 64'(psel_o), 64'd0);

    // 4: sub 0 hangs, timeout after 255 ACCESS cycles, then a normal access
    hangCfg[0] = 1;
    applyStimulus(Base + 32'h0010, 1'b0, 4'b1111, 32'h0, 32'h0, 1'b1);
    penCnt = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk_i);
      if (penable_o) penCnt++;
      if (obi_rvalid_o) break;
    end
    checkOutput("t4_penable_cycles", 64'(penCnt), 64'd255);
    checkOutput("t4_rvalid_after_abort", 64'({obi_rvalid_o, penable_o, psel_o}), 64'({1'b1, 1'b0, 4'b0000}));
    hangCfg[0] = 0;
    rdataCfg[0] = 32'hAAAA_5555;
    applyStimulus(Base + 32'h0010, 1'b0, 4'b1111, 32'h0, 32'hAAAA_5555, 1'b0);
    waitResponse("t4_followup_resp", 10);

    // 5: slave error from sub 2; stray pready/pslverr on sub 0 must be ignored
    errCfg[2] = 1; waitCfg[2] = 1; rdataCfg[2] = 32'hCAFE_0001;
    strayReady[0] = 1; strayErr[0] = 1;
    applyStimulus(Base + 32'h2010, 1'b0, 4'b1111, 32'h0, 32'hCAFE_0001, 1'b1);
    waitResponse("t5_sub2_resp", 10);
    waitCfg[0] = 1; rdataCfg[0] = 32'h0000_0C0C;
    applyStimulus(Base + 32'h0020, 1'b0, 4'b1111, 32'h0, 32'h0000_0C0C, 1'b0);
    waitResponse("t5_sub0_resp", 10);
    strayReady[0] = 0; strayErr[0] = 0; waitCfg[0] = 0;

    // 5b: back-to-back writes with req held high
    waitCfg[1] = 0;
    nGrant = 0;
    @(negedge clk_i);
    obi_req_i = 1'b1; obi_addr_i = Base + 32'h1000; obi_we_i = 1'b1;
    obi_be_i = 4'b1111; obi_wdata_i = 32'h5A5A_A5A5;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (cyc != 0) @(negedge clk_i);
      #1;
      if (obi_gnt_o) begin
        expQ.push_back('{rdata: 32'h0, err: 1'b0});
        grants[nGrant] = cyc;
        nGrant++;
        if (nGrant == 3) begin
          @(posedge clk_i);
          #1;
          obi_req_i = 1'b0;
          break;
        end
      end
    end
    obi_req_i = 1'b0;
    checkOutput("t5_grant_count", 64'(nGrant), 64'd3);
    if (nGrant == 3) begin
      checkOutput("t5_grant_gap1", 64'(grants[1] - grants[0]), 64'd4);
      checkOutput("t5_grant_gap2", 64'(grants[2] - grants[1]), 64'd4);
    end
    waitResponse("t5_b2b_last_resp", 10);

    // 6: reset during ACCESS releases the bus at once and drops the response
    hangCfg[1] = 1;
    applyStimulus(Base + 32'h1000, 1'b0, 4'b1111, 32'h0, 32'h0, 1'b0);
    @(negedge clk_i);
    @(negedge clk_i);
    checkOutput("t6_in_access", 64'({psel_o, penable_o}), 64'({4'b0010, 1'b1}));
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("t6_async_release", 64'({psel_o, penable_o, obi_rvalid_o}), 64'd0);
    expQ.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checkOutput("t6_rst_no_rvalid", 64'(obi_rvalid_o), 64'd0);
    end
    rst_ni = 1'b1;
    hangCfg[1] = 0; rdataCfg[1] = 32'h0BAD_F00D;
    repeat (3) @(negedge clk_i);
    applyStimulus(Base + 32'h1000, 1'b0, 4'b1111, 32'h0, 32'h0BAD_F00D, 1'b0);
    waitResponse("t6_after_reset_resp", 10);

    repeat (2) @(negedge clk_i);
    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/zeroheti_obi_apb_bridge.md
Name: zeroheti_obi_apb_bridge

Overview:
Single-outstanding OBI subordinate to APB4 manager bridge for the core's peripheral window. It is attached to one crossbar manager-side port and fans out to NumApbSbrs APB peripherals, such as the CLIC register file, timer and UART. It decodes the address, runs the APB SETUP/ACCESS sequence and returns one OBI response per request. Unmapped addresses and hung peripherals get an error response.

Parameters:
BaseAddr, 32'h0003_0000, byte base address of the peripheral window.
NumApbSbrs, 4, number of APB subordinates, range 1..16.
SbrSize, 32'h0000_1000, bytes per subordinate region; must be a power of two and at least 4.
TimeoutCycles, 255, number of ACCESS cycles without PREADY before abort; 0 disables the timeout.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
obi_req_i  in  1  OBI request
obi_gnt_o  out  1  OBI grant
obi_addr_i  in  32  byte address
obi_we_i  in  1  1 = write
obi_be_i  in  4  byte enables
obi_wdata_i  in  32  write data
obi_rvalid_o  out  1  response valid
obi_rdata_o  out  32  read data
obi_err_o  out  1  response error
psel_o  out  NumApbSbrs  one-hot APB select
penable_o  out  1  APB enable
pwrite_o  out  1  APB write
paddr_o  out  32  region offset, word aligned
pwdata_o  out  32  APB write data
pstrb_o  out  4  APB strobes
pprot_o  out  3  fixed 3'b000
prdata_i  in  NumApbSbrs*32  per-subordinate read data
pready_i  in  NumApbSbrs  per-subordinate ready
pslverr_i  in  NumApbSbrs  per-subordinate error

Behaviour:
- Reset (rst_ni low, asynchronous):
  - FSM goes to IDLE and the timeout counter clears.
  - All outputs are 0.
  - Latched request fields are 0.
- Decode, combinational on obi_addr_i:
  - offs = addr - BaseAddr.
  - Mapped iff addr >= BaseAddr and offs < NumApbSbrs*SbrSize. Compute with 33-bit arithmetic so there is no wrap at 2^32.
  - idx = offs >> log2(SbrSize).
- obi_gnt_o = obi_req_i && state==IDLE. Grant is combinational and only given in IDLE, so at most one transaction is outstanding.
- On the handshake (req && gnt), latch:
  - we, be, wdata and idx.
  - paddr = offs & (SbrSize-1) with bits [1:0] forced to 0.
  - mapped flag.
- FSM:
  - IDLE -> SETUP on a mapped handshake.
  - IDLE -> RESP on an unmapped handshake, with latched err=1 and rdata=0.
  - SETUP, one cycle: psel_o[idx]=1, penable_o=0; pwrite, paddr and pwdata driven from the latches. Next state ACCESS.
  - ACCESS: psel_o[idx]=1, penable_o=1, counter increments each cycle.
    - If pready_i[idx]: capture rdata=prdata_i[idx] (forced to 0 on writes) and err=pslverr_i[idx]; go to RESP.
    - Else if TimeoutCycles!=0 and counter==TimeoutCycles-1: abort with err=1, rdata=0; go to RESP.
  - RESP, one cycle: obi_rvalid_o=1 with captured rdata and err. psel and penable are 0. Next state IDLE and the counter clears.
- pstrb_o = be on writes and 4'b0000 on reads (APB4 rule).
- APB outputs hold stable across SETUP and all of ACCESS, including wait states.
- obi_rdata_o and obi_err_o are 0 whenever obi_rvalid_o=0.
- Latency with PREADY in the first ACCESS cycle: grant at T0, SETUP T1, ACCESS T2, rvalid T3. Each wait state adds 1 cycle.
- Unmapped access: grant at T0, rvalid at T1.
- Back-to-back: the earliest next grant is the IDLE cycle after RESP, so the minimum spacing is 4 cycles per mapped transfer.
- pready_i or pslverr_i from non-selected subordinates are ignored.
- pslverr_i is sampled only in the cycle pready_i[idx]=1.
- Reset mid-transfer: the bus is released immediately (psel and penable drop asynchronously) and no OBI response is issued.

Test Plan:
1. Write 32'hDEAD_BEEF, be=4'b0011 to BaseAddr+32'h1008, sub 1 zero-wait -> T1: psel=4'b0010, penable=0, paddr=32'h8, pstrb=4'b0011, pwrite=1; T2: penable=1; T3: rvalid=1, err=0, rdata=0.
2. Read BaseAddr+32'h3004, sub 3 ready after 2 wait states with prdata=32'h1234_5678 -> psel=4'b1000 stable for 4 cycles, pstrb=0; rvalid on T5 with rdata=32'h1234_5678.
3. Read BaseAddr+32'h4000 (unmapped) and BaseAddr-4 -> each gets rvalid the next cycle, err=1, rdata=0; psel stays 0.
4. Sub 0 never asserts PREADY, TimeoutCycles=255 -> penable high for exactly 255 cycles, then drops; rvalid with err=1 on the following cycle. A subsequent access succeeds.
5. Sub 2 returns pslverr=1 with pready=1; a pslverr=1 pulse on sub 0 without pready is ignored -> obi_err_o=1 only for sub 2. Back-to-back requests held high -> grants spaced 4 cycles apart.
6. Assert rst_ni low during ACCESS -> psel and penable go 0 within the same cycle, no rvalid. After release, a fresh read completes normally.
